// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text path.
// Holds the default text-grid geometry, the ASCII codes the hex writer
// emits, the writer FSM state type, and two small helpers. One helper
// resolves the digit count. The other left-aligns a value on its first digit.
package vga_pkg;

  localparam int COLS_DEF   = 80;
  localparam int ROWS_DEF   = 30;
  localparam int ADDR_W_DEF = 12;

  localparam logic [7:0] ASCII_0  = 8'h30;  // '0'
  localparam logic [7:0] ASCII_X  = 8'h78;  // 'x'
  localparam logic [7:0] ASCII_UA = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_LA = 8'h61;  // 'a'

  typedef enum logic [1:0] {
    IDLE,
    PFX0,
    PFX1,
    DIG
  } wr_state_t;

  // A digit count of 0, or one above 8, prints the full 32-bit word.
  function automatic logic [3:0] eff_ndig(input logic [3:0] ndig);
    return (ndig == 4'd0 || ndig > 4'd8) ? 4'd8 : ndig;
  endfunction

  // Shift the value so that its most significant printed digit sits in [31:28].
  function automatic logic [31:0] left_align(input logic [31:0] value,
                                             input logic [3:0]  n);
    return value << (5'd4 * (5'd8 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational converter from a hex nibble to its ASCII character.
// Ports:
//   nibble  in  4  value 0..15
//   ascii   out 8  '0'..'9', then 'A'..'F' (UPPER=1) or 'a'..'f' (UPPER=0)
module hex_nibble_to_ascii
  import vga_pkg::*;
#(
  parameter bit UPPER = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'd0, nibble};
    end else begin
      ascii = (UPPER ? ASCII_UA : ASCII_LA) + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_text_writer.sv
// Prints one 32-bit value as hex ASCII into the VGA text buffer write port.
// The value is written one character per clock, with an optional "0x" prefix.
// Ports:
//   clk             in   1       buffer write clock
//   rst             in   1       asynchronous reset, active low
//   req_valid       in   1       request present
//   req_ready       out  1       writer idle and accepting
//   req_value       in   32      value to print
//   req_ndig        in   4       digit count (0 or >8 means 8)
//   req_prefix      in   1       prepend "0x"
//   req_row         in   5       start row
//   req_col         in   7       start column
//   display_wen     out  1       buffer write strobe
//   display_w_addr  out  ADDR_W  cell address (row*COLS + col)
//   display_w_data  out  8       ASCII character
//   done            out  1       one-cycle pulse with the final write
//
// The output registers carry the write for the current state. Each edge
// therefore loads the character belonging to the state being entered. As a
// result, the first write appears in the cycle right after acceptance. In DIG,
// cnt counts the digits still to come after the one on the bus.
module hex_text_writer
  import vga_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit UPPER  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_value,
  input  logic [3:0]        req_ndig,
  input  logic              req_prefix,
  input  logic [4:0]        req_row,
  input  logic [6:0]        req_col,
  output logic              display_wen,
  output logic [ADDR_W-1:0] display_w_addr,
  output logic [7:0]        display_w_data,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  wr_state_t         state, state_nxt;
  logic [31:0]       shreg, shreg_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              wen_nxt, done_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;

  logic [3:0]        acc_n;
  logic [31:0]       acc_value;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              bad_cell;
  logic              accept;
  logic [3:0]        nib;
  logic [7:0]        nib_ascii;

  assign acc_n      = eff_ndig(req_ndig);
  assign acc_value  = left_align(req_value, acc_n);
  assign start_addr = ADDR_W'(int'(req_row) * COLS + int'(req_col));
  assign bad_cell   = (int'(req_row) >= ROWS) || (int'(req_col) >= COLS);
  // The last cell of the screen wraps to cell 0.
  assign addr_inc   = (display_w_addr == LAST_ADDR) ? '0
                                                    : display_w_addr + ADDR_W'(1);
  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready;

  // In IDLE, the first digit comes straight from the incoming request.
  // This lets the first digit land on the bus one cycle after acceptance.
  assign nib = (state == IDLE) ? acc_value[31:28] : shreg[31:28];

  hex_nibble_to_ascii #(
    .UPPER(UPPER)
  ) u_nib (
    .nibble(nib),
    .ascii (nib_ascii)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path leaves one unassigned and no latch is inferred.
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    wen_nxt   = 1'b0;
    done_nxt  = 1'b0;
    addr_nxt  = display_w_addr;
    data_nxt  = display_w_data;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_cell) begin
            done_nxt = 1'b1;
          end else begin
            wen_nxt  = 1'b1;
            addr_nxt = start_addr;
            if (req_prefix) begin
              state_nxt = PFX0;
              data_nxt  = ASCII_0;
              shreg_nxt = acc_value;
              cnt_nxt   = acc_n;
            end else begin
              state_nxt = DIG;
              data_nxt  = nib_ascii;
              shreg_nxt = acc_value << 4;
              cnt_nxt   = acc_n - 4'd1;
              done_nxt  = (acc_n == 4'd1);
            end
          end
        end
      end

      PFX0: begin
        state_nxt = PFX1;
        wen_nxt   = 1'b1;
        addr_nxt  = addr_inc;
        data_nxt  = ASCII_X;
      end

      PFX1, DIG: begin
        if (state == DIG && cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DIG;
          wen_nxt   = 1'b1;
          addr_nxt  = addr_inc;
          data_nxt  = nib_ascii;
          shreg_nxt = shreg << 4;
          cnt_nxt   = cnt - 4'd1;
          done_nxt  = (cnt == 4'd1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      display_wen    <= 1'b0;
      display_w_addr <= '0;
      display_w_data <= '0;
      done           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples values from before the edge.
      state          <= state_nxt;
      shreg          <= shreg_nxt;
      cnt            <= cnt_nxt;
      display_wen    <= wen_nxt;
      display_w_addr <= addr_nxt;
      display_w_data <= data_nxt;
      done           <= done_nxt;
    end
  end

endmodule

// File: tb/tb_hex_text_writer.sv
// Self-checking bench for hex_text_writer.
// Stimulus pushes the expected writes into scoreboard queues. A negedge
// monitor pops one entry per observed write or done pulse. Each entry is
// tagged with the clock index where it must appear. Two writers run side by
// side on the same stimulus, one upper-case and one lower-case.
module tb_hex_text_writer;

  typedef struct packed {
    logic [31:0] cyc;
    logic        wen;
    logic        done;
    logic [11:0] addr;
    logic [7:0]  data;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_value;
  logic [3:0]  req_ndig;
  logic        req_prefix;
  logic [4:0]  req_row;
  logic [6:0]  req_col;

  logic        ready_u, wen_u, done_u;
  logic [11:0] addr_u;
  logic [7:0]  data_u;
  logic        ready_l, wen_l, done_l;
  logic [11:0] addr_l;
  logic [7:0]  data_l;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  obs_t exp_up[$];
  obs_t exp_lo[$];
  obs_t o_u, o_l, e_u, e_l;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hex_text_writer u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_u),
    .req_value(req_value), .req_ndig(req_ndig), .req_prefix(req_prefix),
    .req_row(req_row), .req_col(req_col), .display_wen(wen_u),
    .display_w_addr(addr_u), .display_w_data(data_u), .done(done_u)
  );

  hex_text_writer #(.UPPER(1'b0)) u_dut_lc (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_l),
    .req_value(req_value), .req_ndig(req_ndig), .req_prefix(req_prefix),
    .req_row(req_row), .req_col(req_col), .display_wen(wen_l),
    .display_w_addr(addr_l), .display_w_data(data_l), .done(done_l)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h46) ? c + 8'h20 : c;
  endfunction

  // Queue the writes of string s, starting at addr0 and at clock index pa.
  task automatic push_seq(input int pa, input int addr0, input string s, input bit final_done);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] ch;
      logic       last;
      ch   = s[i];
      last = final_done && (i == s.len() - 1);
      exp_up.push_back('{cyc: pa + i, wen: 1'b1, done: last,
                         addr: 12'((addr0 + i) % 2400), data: ch});
      exp_lo.push_back('{cyc: pa + i, wen: 1'b1, done: last,
                         addr: 12'((addr0 + i) % 2400), data: to_lower(ch)});
    end
  endtask

  task automatic push_done_only(input int pa);
    exp_up.push_back('{cyc: pa, wen: 1'b0, done: 1'b1, addr: 12'd0, data: 8'd0});
    exp_lo.push_back('{cyc: pa, wen: 1'b0, done: 1'b1, addr: 12'd0, data: 8'd0});
  endtask

  // Present a request at a negedge and wait (bounded) for acceptance.
  // pa is set to the index of the accepting edge, or -1 if none came.
  task automatic issue(input logic [31:0] value, input logic [3:0] ndig, input logic prefix,
                       input logic [4:0] row, input logic [6:0] col, input bit hold,
                       output int pa);
    logic rdy;
    pa = -1;
    @(negedge clk);
    req_value  = value;
    req_ndig   = ndig;
    req_prefix = prefix;
    req_row    = row;
    req_col    = col;
    req_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = ready_u;
      @(posedge clk);
      #1;
      if (rdy) begin
        pa = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!hold) req_valid = 1'b0;
    if (pa < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no acceptance want acceptance of value %h", value);
    end
  endtask

  task automatic drain(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_up.size() == 0 && exp_lo.size() == 0 && ready_u) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending want 0", name, exp_up.size() + exp_lo.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (wen_u || done_u) begin
      o_u = '{cyc: cyc, wen: wen_u, done: done_u, addr: addr_u, data: data_u};
      if (exp_up.size() == 0) begin
        total++;
        bad++;
        $display("FAIL up_unexpected: got %h want no activity", o_u);
      end else begin
        e_u = exp_up.pop_front();
        if (!e_u.wen) begin
          o_u.addr = '0;
          o_u.data = '0;
        end
        check("up_write", 64'(o_u), 64'(e_u));
      end
    end
    if (wen_l || done_l) begin
      o_l = '{cyc: cyc, wen: wen_l, done: done_l, addr: addr_l, data: data_l};
      if (exp_lo.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lo_unexpected: got %h want no activity", o_l);
      end else begin
        e_l = exp_lo.pop_front();
        if (!e_l.wen) begin
          o_l.addr = '0;
          o_l.data = '0;
        end
        check("lo_write", 64'(o_l), 64'(e_l));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pa;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_value  = '0;
    req_ndig   = '0;
    req_prefix = 1'b0;
    req_row    = '0;
    req_col    = '0;

    #1;
    check("rst_wen",   64'(wen_u),   64'd0);
    check("rst_addr",  64'(addr_u),  64'd0);
    check("rst_data",  64'(data_u),  64'd0);
    check("rst_done",  64'(done_u),  64'd0);
    check("rst_ready", 64'(ready_u), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Basic write: "ABCD" at row 2, col 10, which is cell 170.
    issue(32'h0000ABCD, 4'd4, 1'b0, 5'd2, 7'd10, 1'b0, pa);
    if (pa >= 0) begin
      push_seq(pa, 170, "ABCD", 1'b1);
      while (cyc != pa + 3) @(negedge clk);
      check("basic_busy_at_last", 64'(ready_u), 64'd0);
      @(negedge clk);
      check("basic_ready_after", 64'(ready_u), 64'd1);
    end
    drain("basic");

    // Prefix with full width (ndig=0 means 8 digits).
    issue(32'hDEADBEEF, 4'd0, 1'b1, 5'd0, 7'd0, 1'b0, pa);
    if (pa >= 0) push_seq(pa, 0, "0xDEADBEEF", 1'b1);
    drain("prefix");

    // Wrap from the last cell of the screen back to cell 0.
    issue(32'h00001234, 4'd4, 1'b0, 5'd29, 7'd78, 1'b0, pa);
    if (pa >= 0) push_seq(pa, 2398, "1234", 1'b1);
    drain("wrap");

    // Bad start cell: col past the end, then row past the end.
    issue(32'h0000ABCD, 4'd4, 1'b0, 5'd0, 7'd80, 1'b0, pa);
    if (pa >= 0) begin
      push_done_only(pa);
      check("badcol_ready_a", 64'(ready_u), 64'd1);
      @(negedge clk);
      check("badcol_ready_b", 64'(ready_u), 64'd1);
    end
    drain("badcol");
    issue(32'h0000ABCD, 4'd9, 1'b1, 5'd30, 7'd0, 1'b0, pa);
    if (pa >= 0) begin
      push_done_only(pa);
      check("badrow_ready", 64'(ready_u), 64'd1);
    end
    drain("badrow");

    // Reset mid-operation, asserted between edges during the third write.
    issue(32'h89ABCDEF, 4'd8, 1'b0, 5'd5, 7'd0, 1'b0, pa);
    if (pa >= 0) begin
      push_seq(pa, 400, "89", 1'b0);
      while (cyc < pa + 2) begin
        @(posedge clk);
        #1;
      end
      #1;
      rst = 1'b0;
      #1;
      check("midrst_wen",   64'(wen_u),   64'd0);
      check("midrst_done",  64'(done_u),  64'd0);
      check("midrst_ready", 64'(ready_u), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
    end
    issue(32'h00000005, 4'd1, 1'b0, 5'd1, 7'd1, 1'b0, pa);
    if (pa >= 0) push_seq(pa, 81, "5", 1'b1);
    drain("after_rst");

    // Back-to-back requests with valid held high, plus junk inputs while busy.
    issue(32'h00000007, 4'd1, 1'b0, 5'd3, 7'd0, 1'b1, pa);
    if (pa >= 0) begin
      push_seq(pa, 240, "7", 1'b1);
      check("b2b_busy", 64'(ready_u), 64'd0);
      req_value  = 32'hFFFFFFFF;
      req_ndig   = 4'd8;
      req_prefix = 1'b1;
      req_row    = 5'd0;
      req_col    = 7'd0;
      @(posedge clk);
      #1;
      check("b2b_idle_slot", 64'(ready_u), 64'd1);
      req_value  = 32'h000000F0;
      req_ndig   = 4'd2;
      req_prefix = 1'b0;
      req_row    = 5'd3;
      req_col    = 7'd5;
      @(posedge clk);
      #1;
      push_seq(pa + 2, 245, "F0", 1'b1);
      check("b2b_second_accept", 64'(ready_u), 64'd0);
    end
    req_valid = 1'b0;
    drain("b2b");

    check("up_leftover", 64'(exp_up.size()), 64'd0);
    check("lo_leftover", 64'(exp_lo.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
